// File: rtl/mux4to1_5b_sync_pkg.sv
// Shared select encoding for the small datapath muxes.
package mux4to1_5b_sync_pkg;

  // 2-bit operand select; all four codes are legal.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

  // One-hot form of a select code: bit k set when operand Ik is chosen.
  function automatic logic [3:0] sel_onehot(input sel_t sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mux4to1_5b_sync_if.sv
// Operand/select bundle and registered result of the 4:1 select register.
interface mux4to1_5b_sync_if #(
  parameter int WIDTH = 5
);
  import mux4to1_5b_sync_pkg::*;

  logic             en;
  sel_t             s;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I3;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic [3:0]       sel_oh;

  // Source of operands and select; consumer of the registered result.
  modport master (
    output en, s, I0, I1, I2, I3,
    input  o, o_valid, sel_oh
  );

  // The select register itself.
  modport slave (
    input  en, s, I0, I1, I2, I3,
    output o, o_valid, sel_oh
  );

endinterface

// File: rtl/mux4to1_5b_sync_comb.sv
// Pure WIDTH-bit 4:1 selector, no state.
module mux4to1_5b_comb
  import mux4to1_5b_sync_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  sel_t             s,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [WIDTH-1:0] y
);

  // Full decode of the select: every code maps to an operand.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves y unassigned (no latch).
    y = '0;
    case (s)
      SEL_I0: y = I0;
      SEL_I1: y = I1;
      SEL_I2: y = I2;
      SEL_I3: y = I3;
    endcase
  end

endmodule

// File: rtl/mux4to1_5b_sync.sv
// Registered 4:1 operand select with validity flag and one-hot select echo.
module mux4to1_5b_sync
  import mux4to1_5b_sync_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux4to1_5b_sync_if.slave       bus
);

  logic [WIDTH-1:0] sel_data;

  mux4to1_5b_comb #(
    .WIDTH (WIDTH)
  ) u_sel (
    .s  (bus.s),
    .I0 (bus.I0),
    .I1 (bus.I1),
    .I2 (bus.I2),
    .I3 (bus.I3),
    .y  (sel_data)
  );

  // Output register: reset clears, enable captures operand and select together, else hold.
  always_ff @(posedge clk) begin
    // NOTE: rst_n is only looked at on the clock edge (synchronous reset), and state uses <= so all
    // three outputs update from the same pre-edge values.
    if (!rst_n) begin
      bus.o       <= RESET_VAL;
      bus.o_valid <= 1'b0;
      bus.sel_oh  <= 4'b0000;
    end else if (bus.en) begin
      bus.o       <= sel_data;
      bus.o_valid <= 1'b1;
      bus.sel_oh  <= sel_onehot(bus.s);
    end
  end

endmodule

// File: tb/tb_mux4to1_5b_sync.sv
// Directed bench for the registered 4:1 select: vector table plus multi-cycle sequences.
module tb_mux4to1_5b_sync;
  import mux4to1_5b_sync_pkg::*;

  localparam int WIDTH = 5;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  mux4to1_5b_sync_if #(.WIDTH(WIDTH)) bus ();

  mux4to1_5b_sync #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             en;
    logic [1:0]       s;
    logic [WIDTH-1:0] i0, i1, i2, i3;
    logic [WIDTH-1:0] exp_o;
    logic             exp_valid;
    logic [3:0]       exp_oh;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [WIDTH-1:0] eo,
                           input logic ev, input logic [3:0] eoh);
    check({name, ".o"},       32'(bus.o),       32'(eo));
    check({name, ".o_valid"}, 32'(bus.o_valid), 32'(ev));
    check({name, ".sel_oh"},  32'(bus.sel_oh),  32'(eoh));
  endtask

  task automatic set_ops(input logic [WIDTH-1:0] a, b, c, d);
    bus.I0 = a; bus.I1 = b; bus.I2 = c; bus.I3 = d;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.s  = SEL_I0;
    set_ops('0, '0, '0, '0);

    //          rst en  s      I0  I1  I2  I3   o  v  oh
    vecs[0] = '{1'b0, 1'b1, 2'd1,  1,  2,  3,  4,  0, 1'b0, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 2'd1,  1,  2,  3,  4,  0, 1'b0, 4'b0000};
    vecs[2] = '{1'b1, 1'b1, 2'd0,  1,  2,  3,  4,  1, 1'b1, 4'b0001};
    vecs[3] = '{1'b1, 1'b1, 2'd1,  1,  2,  3,  4,  2, 1'b1, 4'b0010};
    vecs[4] = '{1'b1, 1'b1, 2'd2,  1,  2,  3,  4,  3, 1'b1, 4'b0100};
    vecs[5] = '{1'b1, 1'b1, 2'd3,  1,  2,  3,  4,  4, 1'b1, 4'b1000};
    vecs[6] = '{1'b1, 1'b1, 2'd0, 31,  0, 21, 10, 31, 1'b1, 4'b0001};
    vecs[7] = '{1'b1, 1'b1, 2'd1, 31,  0, 21, 10,  0, 1'b1, 4'b0010};
    vecs[8] = '{1'b1, 1'b1, 2'd2, 31,  0, 21, 10, 21, 1'b1, 4'b0100};
    vecs[9] = '{1'b1, 1'b1, 2'd3, 31,  0, 21, 10, 10, 1'b1, 4'b1000};

    #2;
    // Reset, select sweep and width extremes.
    for (int i = 0; i < 10; i++) begin
      rst_n  = vecs[i].rst_n;
      bus.en = vecs[i].en;
      bus.s  = vecs[i].s;
      set_ops(vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].i3);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_valid, vecs[i].exp_oh);
    end

    // Latency and isolation: mid-cycle changes are invisible until the next edge.
    set_ops(1, 2, 3, 4);
    bus.s = SEL_I2;
    tick();
    check_all("lat_cap", 3, 1'b1, 4'b0100);
    bus.s  = SEL_I3;
    bus.I2 = 31;
    #2;
    check_all("lat_mid", 3, 1'b1, 4'b0100);
    tick();
    check_all("lat_next", 4, 1'b1, 4'b1000);

    // Enable hold for three edges, then re-enable.
    set_ops(1, 2, 3, 4);
    bus.s = SEL_I1;
    tick();
    check_all("hold_cap", 2, 1'b1, 4'b0010);
    bus.en = 1'b0;
    bus.s  = SEL_I3;
    bus.I1 = 17;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("hold%0d", k), 2, 1'b1, 4'b0010);
    end
    bus.en = 1'b1;
    tick();
    check_all("hold_reen", 4, 1'b1, 4'b1000);

    // Mid-operation reset: no effect before the edge, clears at the edge despite en=1.
    rst_n = 1'b0;
    #2;
    check_all("rst_pre_edge", 4, 1'b1, 4'b1000);
    tick();
    check_all("rst_edge", 0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    bus.s = SEL_I0;
    #2;
    check_all("rst_rel_mid", 0, 1'b0, 4'b0000);
    tick();
    check_all("rst_reload", 1, 1'b1, 4'b0001);

    // After reset with en low the outputs stay cleared and invalid.
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    bus.en = 1'b0;
    bus.s  = SEL_I2;
    tick();
    check_all("rst_hold", 0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
